// File: rtl/sort_engine_param_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sort_pkg
//  Description : Shared types and helpers for the parametrised bubble sorter:
//                FSM state encoding and the address-width calculation.
//  Revision    : 1.0  initial release
// ============================================================================
package sort_pkg;

    // Sorter FSM states; explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Address width needed to index DEPTH words (never below one bit)
    function automatic int addr_w_calc(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sort_engine_param_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sort_engine_param_if
//  Description : Control handshake plus dual-port memory bus of the sorter.
//                master = the sort engine, slave = controller/memory side.
//  Revision    : 1.0  initial release
// ============================================================================
interface sort_engine_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              start;
    logic              desc;
    logic              busy;
    logic              done;
    logic              pass_done;
    logic [ADDR_W-1:0] pass_cnt;
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              we;
    logic [DATA_W-1:0] wr_data1;
    logic [DATA_W-1:0] wr_data2;

    modport master (
        input  start, desc, rd_data1, rd_data2,
        output busy, done, pass_done, pass_cnt, addr1, addr2,
               we, wr_data1, wr_data2
    );

    modport slave (
        output start, desc, rd_data1, rd_data2,
        input  busy, done, pass_done, pass_cnt, addr1, addr2,
               we, wr_data1, wr_data2
    );
endinterface
`default_nettype wire

// File: rtl/sort_engine_param_cmp_swap.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sort_cmp_swap
//  Description : Combinational compare-swap of one adjacent pair. swap flags
//                an out-of-order pair; lo_out/hi_out are always the swapped
//                pair so the caller only has to gate the write enable.
//  Revision    : 1.0  initial release
// ============================================================================
module sort_cmp_swap #(
    parameter int DATA_W = 8,
    parameter bit SIGNED = 1'b0
) (
    input  wire logic [DATA_W-1:0] a,
    input  wire logic [DATA_W-1:0] b,
    input  wire logic              desc,
    output logic                   swap,
    output logic [DATA_W-1:0]      lo_out,
    output logic [DATA_W-1:0]      hi_out
);
    logic w_gt;
    logic w_lt;

    // Magnitude comparison, two's-complement or unsigned by parameter
    generate
        if (SIGNED) begin : g_signed
            assign w_gt = ($signed(a) > $signed(b));
            assign w_lt = ($signed(a) < $signed(b));
        end else begin : g_unsigned
            assign w_gt = (a > b);
            assign w_lt = (a < b);
        end
    endgenerate

    // Strict inequality: equal words never swap, which keeps the sort stable
    assign swap   = desc ? w_lt : w_gt;
    assign lo_out = b;
    assign hi_out = a;

endmodule
`default_nettype wire

// File: rtl/sort_engine_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sort_engine_param
//  Description : In-place bubble sorter over a dual-port async-read memory.
//                One compare-swap per cycle, shrinking pass length, early
//                exit after a swap-free pass, runtime asc/desc mode.
//  Revision    : 1.0  initial release
// ============================================================================
module sort_engine_param
    import sort_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter bit SIGNED = 1'b0,
    parameter int ADDR_W = addr_w_calc(DEPTH)
) (
    input  wire logic           clk,
    input  wire logic           reset,
    sort_engine_param_if.master bus
);
    // Last pair index of pass 0 and the final permitted pass index coincide
    localparam logic [ADDR_W-1:0] c_last_k = ADDR_W'(DEPTH - 2);
    localparam logic [ADDR_W-1:0] c_one    = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [ADDR_W-1:0] pass_q, pass_d;
    logic              swapped_q, swapped_d;
    logic              mode_q, mode_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              w_swap;
    logic [DATA_W-1:0] w_lo;
    logic [DATA_W-1:0] w_hi;
    logic              w_in_scan;
    logic              w_pass_end;
    logic              w_swapped_now;

    sort_cmp_swap #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
    ) u_cmp (
        .a      (bus.rd_data1),
        .b      (bus.rd_data2),
        .desc   (mode_q),
        .swap   (w_swap),
        .lo_out (w_lo),
        .hi_out (w_hi)
    );

    assign w_in_scan     = (state_q == ST_SCAN);
    assign w_pass_end    = (k_q == (c_last_k - pass_q));
    assign w_swapped_now = swapped_q | w_swap;

    // Next-state logic: pair walk, pass advance, early exit, completion
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        pass_d    = pass_q;
        swapped_d = swapped_q;
        mode_d    = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_SCAN;
                    k_d       = '0;
                    pass_d    = '0;
                    swapped_d = 1'b0;
                    mode_d    = bus.desc;
                end
            end
            ST_SCAN: begin
                if (w_pass_end) begin
                    k_d = '0;
                    if (!w_swapped_now || (pass_q == c_last_k)) begin
                        state_d = ST_FIN;
                    end else begin
                        pass_d    = pass_q + c_one;
                        swapped_d = 1'b0;
                    end
                end else begin
                    k_d       = k_q + c_one;
                    swapped_d = w_swapped_now;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_SCAN);
        done_d = (state_d == ST_FIN);
    end

    // State and counter registers; async reset clears everything at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            pass_q    <= '0;
            swapped_q <= 1'b0;
            mode_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            pass_q    <= pass_d;
            swapped_q <= swapped_d;
            mode_q    <= mode_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Outputs: write enable and write data only live while scanning, so a
    // reset (state back to IDLE) removes any pending write immediately
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass_done = w_in_scan & w_pass_end;
    assign bus.pass_cnt  = pass_q;
    assign bus.addr1     = k_q;
    assign bus.addr2     = k_q + c_one;
    assign bus.we        = w_in_scan & w_swap;
    assign bus.wr_data1  = w_in_scan ? w_lo : '0;
    assign bus.wr_data2  = w_in_scan ? w_hi : '0;

endmodule
`default_nettype wire
